// File: rtl/vga_timing_pkg.sv
// Beam timing constants shared with the VGA sync generator, plus scheduler types.
package vga_timing_pkg;

   localparam int H_DISPLAY = 640;
   localparam int H_MAX     = 799;
   localparam int V_DISPLAY = 480;
   localparam int V_MAX     = 524;

   localparam int WD_W      = 12;
   localparam int WD_CYCLES = 4095;

   typedef enum logic [1:0] {
      IDLE,
      ARB,
      GRANT
   } sched_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set bit of cand searching upward
// from (last_idx + 1) mod N_REQ.
module rr_picker #(
   parameter int  N_REQ = 4,
   localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] cand,
   input  logic [IW-1:0]    last_idx,
   output logic [IW-1:0]    win_idx,
   output logic             valid
);

   int idx;

   always_comb begin
      // NOTE: every output gets a default before the search loop, so no path leaves it unassigned and no latch is inferred.
      valid   = 1'b0;
      win_idx = '0;
      idx     = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last_idx) + k) % N_REQ;
         if (!valid && cand[IW'(idx)]) begin
            valid   = 1'b1;
            win_idx = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/vblank_update_scheduler.sv
// Grants game-state update engines one at a time inside vertical blanking.
// Optional per-grant watchdog enabled by defining UPDATE_WATCHDOG_EN.
module vblank_update_scheduler #(
   parameter int N_REQ     = 4,
   parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
   parameter int V_MAX     = vga_timing_pkg::V_MAX,
   parameter int H_MAX     = vga_timing_pkg::H_MAX,
   parameter int WD_CYCLES = vga_timing_pkg::WD_CYCLES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [9:0]       hpos,
   input  logic [9:0]       vpos,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] done,
   output logic [N_REQ-1:0] grant,
   output logic             window_open,
   output logic             frame_tick,
   output logic [7:0]       frame_cnt,
   output logic             overrun,
   output logic             timeout,
   output logic             busy
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   vga_timing_pkg::sched_state_t state, state_n;

   logic [N_REQ-1:0] served, served_n, grant_n;
   logic [IW-1:0]    last_idx, last_n, win_idx, win_n, pick_idx;
   logic             pick_valid, window_n, tick_n, overrun_n;
   logic [7:0]       cnt_n;
   logic             start_cond, end_cond;

   assign start_cond = (vpos == 10'(V_DISPLAY)) && (hpos == 10'd0);
   assign end_cond   = (vpos == 10'(V_MAX)) && (hpos == 10'(H_MAX));
   assign busy       = |grant;

   rr_picker #(.N_REQ(N_REQ)) u_picker (
      .cand     (req & ~served),
      .last_idx (last_idx),
      .win_idx  (pick_idx),
      .valid    (pick_valid)
   );

`ifdef UPDATE_WATCHDOG_EN
   localparam int              WDW      = vga_timing_pkg::WD_W;
   localparam logic [WDW-1:0]  WD_LIMIT = WDW'(WD_CYCLES);
   logic [WDW-1:0] wd, wd_n;
   logic           timeout_n;
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_n   = state;
      grant_n   = grant;
      window_n  = window_open;
      tick_n    = 1'b0;
      cnt_n     = frame_cnt;
      overrun_n = 1'b0;
      served_n  = served;
      last_n    = last_idx;
      win_n     = win_idx;
`ifdef UPDATE_WATCHDOG_EN
      wd_n      = wd;
      timeout_n = 1'b0;
`endif
      case (state)
         vga_timing_pkg::IDLE: begin
            if (start_cond) begin
               window_n = 1'b1;
               tick_n   = 1'b1;
               cnt_n    = frame_cnt + 8'd1;
               served_n = '0;
               state_n  = vga_timing_pkg::ARB;
            end
         end
         vga_timing_pkg::ARB: begin
            if (end_cond) begin
               window_n = 1'b0;
               state_n  = vga_timing_pkg::IDLE;
            end else if (pick_valid) begin
               grant_n = N_REQ'(1) << pick_idx;
               win_n   = pick_idx;
               state_n = vga_timing_pkg::GRANT;
`ifdef UPDATE_WATCHDOG_EN
               wd_n    = '0;
`endif
            end
         end
         vga_timing_pkg::GRANT: begin
            // A done coinciding with window end still counts as served, with no overrun.
            if (done[win_idx]) begin
               served_n[win_idx] = 1'b1;
               last_n            = win_idx;
               grant_n           = '0;
               if (end_cond) begin
                  window_n = 1'b0;
                  state_n  = vga_timing_pkg::IDLE;
               end else begin
                  state_n  = vga_timing_pkg::ARB;
               end
            end else if (end_cond) begin
               grant_n   = '0;
               overrun_n = 1'b1;
               window_n  = 1'b0;
               state_n   = vga_timing_pkg::IDLE;
            end
`ifdef UPDATE_WATCHDOG_EN
            else if (wd == WD_LIMIT) begin
               grant_n           = '0;
               timeout_n         = 1'b1;
               served_n[win_idx] = 1'b1;
               last_n            = win_idx;
               state_n           = vga_timing_pkg::ARB;
            end else begin
               wd_n = wd + 1'b1;
            end
`endif
         end
         default: state_n = vga_timing_pkg::IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= vga_timing_pkg::IDLE;
         grant       <= '0;
         window_open <= 1'b0;
         frame_tick  <= 1'b0;
         frame_cnt   <= '0;
         overrun     <= 1'b0;
         served      <= '0;
         last_idx    <= IW'(N_REQ - 1);
         win_idx     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state       <= state_n;
         grant       <= grant_n;
         window_open <= window_n;
         frame_tick  <= tick_n;
         frame_cnt   <= cnt_n;
         overrun     <= overrun_n;
         served      <= served_n;
         last_idx    <= last_n;
         win_idx     <= win_n;
      end
   end

`ifdef UPDATE_WATCHDOG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd      <= '0;
         timeout <= 1'b0;
      end else begin
         wd      <= wd_n;
         timeout <= timeout_n;
      end
   end
`endif

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Directed bench for vblank_update_scheduler (default build, watchdog disabled);
// the beam position is driven directly so frames can be jumped through quickly.
module tb_vblank_update_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] hpos, vpos;
   logic [3:0] req, done, grant;
   logic       window_open, frame_tick, overrun, timeout, busy;
   logic [7:0] frame_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   vblank_update_scheduler #(.N_REQ(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .hpos        (hpos),
      .vpos        (vpos),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .window_open (window_open),
      .frame_tick  (frame_tick),
      .frame_cnt   (frame_cnt),
      .overrun     (overrun),
      .timeout     (timeout),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beam(input int v, input int h);
      vpos = 10'(v);
      hpos = 10'(h);
   endtask

   task automatic start_frame();
      beam(480, 0);
      tick();
      beam(481, 1);
   endtask

   task automatic end_frame();
      beam(524, 799);
      tick();
      beam(100, 5);
   endtask

   initial begin
      rst_n = 1'b0;
      req   = '0;
      done  = '0;
      beam(100, 5);
      repeat (2) tick();
      check("rst_grant",   grant, 0);
      check("rst_window",  window_open, 0);
      check("rst_tick",    frame_tick, 0);
      check("rst_cnt",     frame_cnt, 0);
      check("rst_overrun", overrun, 0);
      check("rst_timeout", timeout, 0);
      check("rst_busy",    busy, 0);
      rst_n = 1'b1;
      tick();
      check("idle_grant", grant, 0);

      // Frame 1: all four engines served in order with one idle cycle between grants.
      req = 4'b1111;
      start_frame();
      check("f1_window", window_open, 1);
      check("f1_tick",   frame_tick, 1);
      check("f1_cnt",    frame_cnt, 1);
      check("f1_nogrant_yet", grant, 0);
      tick();
      check("f1_tick_off", frame_tick, 0);
      check("f1_busy", busy, 1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("f1_grant%0d", i), grant, 32'(1 << i));
         repeat (3) tick();
         check($sformatf("f1_hold%0d", i), grant, 32'(1 << i));
         if (i == 1) begin
            done = 4'b1000;
            tick();
            done = '0;
            check("f1_foreign_done_ignored", grant, 4'b0010);
         end
         done = 4'(1 << i);
         tick();
         done = '0;
         check($sformatf("f1_gap%0d", i), grant, 0);
         tick();
      end
      check("f1_all_served", grant, 0);
      tick();
      check("f1_still_none", grant, 0);
      end_frame();
      check("f1_window_closed", window_open, 0);
      check("f1_no_overrun", overrun, 0);

      // Frame 2: engine 2 never completes; grant survives req drop, overruns at end.
      req = 4'b0100;
      start_frame();
      check("f2_cnt", frame_cnt, 2);
      tick();
      check("f2_grant2", grant, 4'b0100);
      repeat (5) tick();
      req = '0;
      repeat (3) tick();
      check("f2_held_after_req_drop", grant, 4'b0100);
      end_frame();
      check("f2_grant_dropped", grant, 0);
      check("f2_overrun", overrun, 1);
      check("f2_window_closed", window_open, 0);
      check("f2_busy", busy, 0);
      check("f2_timeout", timeout, 0);
      tick();
      check("f2_overrun_pulse", overrun, 0);

      // Frame 3: engine 2 regranted, then not regranted while req stays high.
      req = 4'b0100;
      start_frame();
      tick();
      check("f3_regrant2", grant, 4'b0100);
      done = 4'b0100;
      tick();
      done = '0;
      check("f3_released", grant, 0);
      repeat (4) tick();
      check("f3_no_regrant", grant, 0);
      end_frame();
      check("f3_window_closed", window_open, 0);
      repeat (3) tick();
      check("f3_idle_no_grant", grant, 0);

      // Frame 4: done lands on the same cycle as window end.
      req = 4'b0001;
      start_frame();
      tick();
      check("f4_grant0", grant, 4'b0001);
      done = 4'b0001;
      beam(524, 799);
      tick();
      done = '0;
      beam(100, 5);
      check("f4_grant_dropped", grant, 0);
      check("f4_no_overrun", overrun, 0);
      check("f4_window_closed", window_open, 0);

      // Frame 5: last_idx=0 from frame 4, so engine 1 wins first.
      req = 4'b1111;
      start_frame();
      check("f5_cnt", frame_cnt, 5);
      tick();
      check("f5_rr_grant1", grant, 4'b0010);

      // Asynchronous reset in the middle of a grant.
      beam(490, 3);
      rst_n = 1'b0;
      #1;
      check("mid_rst_grant",  grant, 0);
      check("mid_rst_window", window_open, 0);
      check("mid_rst_cnt",    frame_cnt, 0);
      check("mid_rst_busy",   busy, 0);
      tick();
      rst_n = 1'b1;
      repeat (5) tick();
      check("post_rst_no_grant",  grant, 0);
      check("post_rst_no_window", window_open, 0);
      start_frame();
      check("post_rst_cnt", frame_cnt, 1);
      tick();
      check("post_rst_grant0", grant, 4'b0001);
      req = '0;
      end_frame();
      tick();

      // Frames 2..255 then wrap to 0.
      for (int f = 2; f <= 255; f++) begin
         start_frame();
         end_frame();
      end
      check("cnt_255", frame_cnt, 255);
      start_frame();
      check("cnt_wrap", frame_cnt, 0);
      check("wrap_tick", frame_tick, 1);
      end_frame();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/vblank_update_scheduler.md
Name: vblank_update_scheduler

Overview:
- Sequences game-state updates into vertical blanking, driven by the beam position from the VGA sync generator.
- Up to N_REQ update engines (player, bullets, invader march, score) share the single game-state write window.
- Each engine is granted at most once per frame, round-robin, with a req/grant/done handshake.
- Signals frame start, counts frames, and flags engines that overrun blanking.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- V_DISPLAY, 480, first blanking line
- V_MAX, 524, last line of frame
- H_MAX, 799, last pixel of line
- WD_CYCLES, 4095, watchdog limit per grant in clk cycles (12-bit counter)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; asynchronous, active-low
- hpos  in  10  beam x from sync generator
- vpos  in  10  beam y from sync generator
- req  in  N_REQ  update request, level, held until granted
- done  in  N_REQ  1-cycle completion pulse from granted engine
- grant  out  N_REQ  one-hot grant, level
- window_open  out  1  high during scheduling window
- frame_tick  out  1  1-cycle pulse at window start
- frame_cnt  out  8  frames since reset, wraps 255->0
- overrun  out  1  1-cycle pulse: window closed with grant active
- timeout  out  1  1-cycle pulse: watchdog released a grant
- busy  out  1  grant != 0

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset (async assert, sync release): all outputs 0, state IDLE, served mask 0, last_idx = N_REQ-1 so index 0 has first priority.
- Window start condition: vpos==V_DISPLAY && hpos==0. Window end condition: vpos==V_MAX && hpos==H_MAX.
- Start condition seen in IDLE: next cycle window_open=1, frame_tick=1 for one cycle, frame_cnt+1, served cleared, state ARB.
- ARB:
  - Candidates are req & ~served.
  - Priority search starts at (last_idx+1) mod N_REQ.
  - If there is a winner: next cycle grant=onehot(winner), state GRANT, watchdog=0. Latency req->grant is 1 cycle.
  - If there is no winner: stay in ARB.
- GRANT:
  - done[winner]=1: served[winner]=1, last_idx=winner, grant=0 next cycle, state ARB.
  - done on any non-granted index: ignored.
  - req deassert while granted: ignored; only done releases the grant.
- End condition in ARB or GRANT: next cycle window_open=0, grant=0, state IDLE.
  - If a grant was active: overrun=1 for one cycle, served unchanged.
- Simultaneous done and end condition: done takes effect (served set, last_idx updated), no overrun pulse, state IDLE.
- Grant gaps: minimum 1 idle cycle between consecutive grants, so grant is never two-hot, not even for one cycle.
- Start condition outside IDLE: cannot occur; ignored.
- Single-requester case: a requester still high after being served is not regranted until the next window.
- frame_cnt is an 8-bit register; overflow wraps silently.
- Mid-frame reset release: the block stays in IDLE until the next start condition. No partial window.

Optional Feature:
- Macro: UPDATE_WATCHDOG_EN
- Defined:
  - A 12-bit counter runs in GRANT.
  - When it reaches WD_CYCLES with no done: grant=0 next cycle, timeout=1 for one cycle, served[winner]=1, last_idx=winner, state ARB.
  - If done arrives in the same cycle, done wins and there is no timeout.
- Undefined: no counter; timeout tied 0; a grant persists until done or window end.

Decomposition:
- Package vga_timing_pkg:
  - H_DISPLAY/H_MAX/V_DISPLAY/V_MAX constants shared with the sync generator.
  - sched_state_t enum {IDLE, ARB, GRANT}.
  - Watchdog width constant.
- Sub-module rr_picker:
  - Combinational round-robin one-hot selector.
  - Inputs: candidate mask and last_idx. Outputs: winner index and valid.
  - Parameterised by N_REQ; unit-tested alone.

Test Plan:
1. Reset mid-GRANT (rst_n low at vpos=490, grant=0001) -> all outputs 0 immediately; no grant until next vpos=480,hpos=0; frame_cnt=0.
2. req=1111, each engine pulses done 10 cycles after grant -> grants 0001,0010,0100,1000, one idle cycle between each, frame_tick once at vpos=480; next frame starts again at 0001.
3. req=0001 held high all frame -> exactly one grant per window; none while window_open=0.
4. Engine 2 granted, never sends done (macro undefined) -> grant held until vpos=524,hpos=799; overrun pulses once; window_open=0; next frame regrants index 2.
5. Macro defined, engine 1 silent -> grant drops after 4095 cycles, timeout pulses once, engine 2 granted 2 cycles later.
6. Run 256 frames -> frame_cnt wraps 255->0; done on a non-granted index during GRANT is ignored.
